// File: rtl/button_press_classifier.sv
// Button gesture classifier: turns a debounced button level into single-cycle
// press / short_click / double_click / long_press / repeat_tick event pulses.
module button_press_classifier #(
   parameter int unsigned ACTIVE_LOW    = 1,
   parameter int unsigned LONG_CYCLES   = 50_000_000,
   parameter int unsigned DCLICK_CYCLES = 12_500_000,
   parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic press,
   output logic short_click,
   output logic double_click,
   output logic long_press,
   output logic repeat_tick,
   output logic held,
   output logic busy
);

   localparam int unsigned MAX_LD = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
   localparam int unsigned MAX_C  = (MAX_LD > REPEAT_CYCLES) ? MAX_LD : REPEAT_CYCLES;
   localparam int unsigned TW     = $clog2(MAX_C + 1);

   localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_CYCLES - 1);
   localparam logic [TW-1:0] DCLICK_LAST = TW'(DCLICK_CYCLES - 1);
   localparam logic [TW-1:0] REPEAT_LAST = (REPEAT_CYCLES == 0) ? '0 : TW'(REPEAT_CYCLES - 1);
   localparam logic          REPEAT_ON   = (REPEAT_CYCLES != 0);
   localparam logic          POL         = (ACTIVE_LOW != 0);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] PRESS1    = 3'd1;
   localparam logic [2:0] WAIT2     = 3'd2;
   localparam logic [2:0] PRESS2    = 3'd3;
   localparam logic [2:0] LONG_HELD = 3'd4;

   logic          p, p_q, rise, fall;
   logic [2:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          press_d, short_d, dbl_d, long_d, rep_d;

   assign p    = d ^ POL;
   assign rise = p & ~p_q;
   assign fall = ~p & p_q;

   // Next-state, timer and event decisions; timer is cleared on every state entry
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      press_d = 1'b0;
      short_d = 1'b0;
      dbl_d   = 1'b0;
      long_d  = 1'b0;
      rep_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) begin
               press_d = 1'b1;
               timer_d = '0;
               state_d = PRESS1;
            end
         end
         PRESS1: begin
            timer_d = timer_q + TW'(1);
            // Release wins over a coincident long-press expiry
            if (fall) begin
               timer_d = '0;
               state_d = WAIT2;
            end else if (p && timer_q == LONG_LAST) begin
               long_d  = 1'b1;
               timer_d = '0;
               state_d = LONG_HELD;
            end
         end
         WAIT2: begin
            timer_d = timer_q + TW'(1);
            // A second press wins over a coincident gap expiry
            if (rise) begin
               press_d = 1'b1;
               timer_d = '0;
               state_d = PRESS2;
            end else if (timer_q == DCLICK_LAST) begin
               short_d = 1'b1;
               timer_d = '0;
               state_d = IDLE;
            end
         end
         PRESS2: begin
            if (fall) begin
               dbl_d   = 1'b1;
               timer_d = '0;
               state_d = IDLE;
            end
         end
         LONG_HELD: begin
            if (fall) begin
               timer_d = '0;
               state_d = IDLE;
            end else if (REPEAT_ON) begin
               timer_d = timer_q + TW'(1);
               if (timer_q == REPEAT_LAST) begin
                  rep_d   = 1'b1;
                  timer_d = '0;
               end
            end
         end
         default: begin
            timer_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State, timer, edge history and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         // Absorb a button held through reset so it produces no press
         p_q          <= p;
         press        <= 1'b0;
         short_click  <= 1'b0;
         double_click <= 1'b0;
         long_press   <= 1'b0;
         repeat_tick  <= 1'b0;
         held         <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         p_q          <= p;
         press        <= press_d;
         short_click  <= short_d;
         double_click <= dbl_d;
         long_press   <= long_d;
         repeat_tick  <= rep_d;
         held         <= p;
         busy         <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier (ACTIVE_LOW=1, LONG=20, DCLICK=10, REPEAT=5).
module tb_button_press_classifier;

   logic clk = 1'b0;
   logic reset, d;
   logic press, short_click, double_click, long_press, repeat_tick, held, busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Event log, written only from the stimulus process
   int n_press, n_short, n_dbl, n_long, n_rep, n_multi, n_busy;
   int c_press_first, c_press_last, c_short, c_dbl, c_long, c_rep_first, c_rep_last;

   button_press_classifier #(
      .ACTIVE_LOW   (1),
      .LONG_CYCLES  (20),
      .DCLICK_CYCLES(10),
      .REPEAT_CYCLES(5)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .d           (d),
      .press       (press),
      .short_click (short_click),
      .double_click(double_click),
      .long_press  (long_press),
      .repeat_tick (repeat_tick),
      .held        (held),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // cyc holds the index of the most recent rising edge
   always @(posedge clk) cyc <= cyc + 1;

   task clear_log();
      n_press = 0; n_short = 0; n_dbl = 0; n_long = 0; n_rep = 0; n_multi = 0; n_busy = 0;
      c_press_first = -1; c_press_last = -1; c_short = -1; c_dbl = -1; c_long = -1;
      c_rep_first = -1; c_rep_last = -1;
   endtask

   // Sample outputs mid-cycle; a pulse seen here was decided at edge cyc
   task tick();
      int s;
      @(negedge clk);
      if (press) begin
         if (n_press == 0) c_press_first = cyc;
         c_press_last = cyc;
         n_press++;
      end
      if (short_click) begin c_short = cyc; n_short++; end
      if (double_click) begin c_dbl = cyc; n_dbl++; end
      if (long_press) begin c_long = cyc; n_long++; end
      if (repeat_tick) begin
         if (n_rep == 0) c_rep_first = cyc;
         c_rep_last = cyc;
         n_rep++;
      end
      if (busy) n_busy++;
      s = int'(press) + int'(short_click) + int'(double_click) + int'(long_press)
        + int'(repeat_tick);
      if (s > 1) n_multi++;
   endtask

   task run(input int n);
      repeat (n) tick();
   endtask

   task test_reset();
      reset = 1'b1;
      d = 1'b1;
      run(3);
      tests++;
      if ({press, short_click, double_click, long_press, repeat_tick, held, busy} !== 7'b0) begin
         fails++;
         $display("FAIL reset_outputs: got %b want 0000000",
                  {press, short_click, double_click, long_press, repeat_tick, held, busy});
      end
      reset = 1'b0;
      run(2);
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
   endtask

   task test_short_click();
      int p, r;
      clear_log();
      d = 1'b0; p = cyc + 1; run(5);
      d = 1'b1; r = cyc + 1; run(15);
      tests++;
      if (n_press !== 1 || c_press_first !== p) begin
         fails++; $display("FAIL t1_press: got n=%0d at %0d want n=1 at %0d", n_press, c_press_first, p);
      end
      tests++;
      if (n_short !== 1 || c_short !== r + 10) begin
         fails++; $display("FAIL t1_short: got n=%0d at %0d want n=1 at %0d", n_short, c_short, r + 10);
      end
      tests++;
      if (n_dbl + n_long + n_rep !== 0) begin
         fails++; $display("FAIL t1_other_events: got %0d want 0", n_dbl + n_long + n_rep);
      end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL t1_busy_after: got %b want 0", busy); end
   endtask

   task test_double_click();
      int p1, p2, r2;
      clear_log();
      d = 1'b0; p1 = cyc + 1; run(4);
      d = 1'b1; run(3);
      d = 1'b0; p2 = cyc + 1; run(4);
      d = 1'b1; r2 = cyc + 1; run(15);
      tests++;
      if (n_press !== 2 || c_press_first !== p1 || c_press_last !== p2) begin
         fails++;
         $display("FAIL t2_press: got n=%0d at %0d/%0d want n=2 at %0d/%0d",
                  n_press, c_press_first, c_press_last, p1, p2);
      end
      tests++;
      if (n_dbl !== 1 || c_dbl !== r2) begin
         fails++; $display("FAIL t2_double: got n=%0d at %0d want n=1 at %0d", n_dbl, c_dbl, r2);
      end
      tests++;
      if (n_short + n_long !== 0) begin
         fails++; $display("FAIL t2_no_short_long: got %0d want 0", n_short + n_long);
      end
   endtask

   task test_long_repeat();
      int p;
      clear_log();
      d = 1'b0; p = cyc + 1; run(5);
      tests++;
      if (held !== 1'b1 || busy !== 1'b1) begin
         fails++; $display("FAIL t3_held_busy: got %b%b want 11", held, busy);
      end
      run(27);
      d = 1'b1; run(15);
      tests++;
      if (n_long !== 1 || c_long !== p + 20) begin
         fails++; $display("FAIL t3_long: got n=%0d at %0d want n=1 at %0d", n_long, c_long, p + 20);
      end
      tests++;
      if (n_rep !== 2 || c_rep_first !== p + 25 || c_rep_last !== p + 30) begin
         fails++;
         $display("FAIL t3_repeat: got n=%0d at %0d/%0d want n=2 at %0d/%0d",
                  n_rep, c_rep_first, c_rep_last, p + 25, p + 30);
      end
      tests++;
      if (n_short + n_dbl !== 0 || busy !== 1'b0 || held !== 1'b0) begin
         fails++;
         $display("FAIL t3_release: got clicks=%0d busy=%b held=%b want 0/0/0",
                  n_short + n_dbl, busy, held);
      end
   endtask

   task test_release_at_expiry();
      int r;
      clear_log();
      d = 1'b0; run(20);
      d = 1'b1; r = cyc + 1; run(15);
      tests++;
      if (n_long !== 0) begin fails++; $display("FAIL t4_no_long: got %0d want 0", n_long); end
      tests++;
      if (n_short !== 1 || c_short !== r + 10) begin
         fails++; $display("FAIL t4_short: got n=%0d at %0d want n=1 at %0d", n_short, c_short, r + 10);
      end
   endtask

   task test_rise_at_expiry();
      int p2, r2;
      clear_log();
      d = 1'b0; run(3);
      d = 1'b1; run(10);
      d = 1'b0; p2 = cyc + 1; run(3);
      d = 1'b1; r2 = cyc + 1; run(15);
      tests++;
      if (n_press !== 2 || c_press_last !== p2) begin
         fails++; $display("FAIL t5_press: got n=%0d last %0d want n=2 last %0d", n_press, c_press_last, p2);
      end
      tests++;
      if (n_short !== 0) begin fails++; $display("FAIL t5_no_short: got %0d want 0", n_short); end
      tests++;
      if (n_dbl !== 1 || c_dbl !== r2) begin
         fails++; $display("FAIL t5_double: got n=%0d at %0d want n=1 at %0d", n_dbl, c_dbl, r2);
      end
   endtask

   task test_reset_mid_gesture();
      d = 1'b0; run(3);
      d = 1'b1; run(4);
      reset = 1'b1; run(1);
      clear_log();
      run(2);
      tests++;
      if ({press, short_click, double_click, long_press, repeat_tick, held, busy} !== 7'b0) begin
         fails++;
         $display("FAIL t6_reset_outputs: got %b want 0000000",
                  {press, short_click, double_click, long_press, repeat_tick, held, busy});
      end
      d = 1'b0; run(2);
      reset = 1'b0; run(20);
      d = 1'b1; run(15);
      tests++;
      if (n_press + n_short + n_dbl + n_long + n_rep !== 0) begin
         fails++;
         $display("FAIL t6_no_events: got %0d want 0", n_press + n_short + n_dbl + n_long + n_rep);
      end
      tests++;
      if (n_busy !== 0) begin fails++; $display("FAIL t6_busy: got %0d busy cycles want 0", n_busy); end
   endtask

   task test_exclusive();
      clear_log();
      d = 1'b0; run(32);
      d = 1'b1; run(3);
      d = 1'b0; run(3);
      d = 1'b1; run(15);
      tests++;
      if (n_multi !== 0) begin fails++; $display("FAIL exclusive: got %0d multi-event cycles want 0", n_multi); end
      tests++;
      if (n_press !== 2 || n_long !== 1 || n_rep !== 2 || n_short !== 1 || n_dbl !== 0) begin
         fails++;
         $display("FAIL mixed_counts: got p%0d l%0d r%0d s%0d d%0d want p2 l1 r2 s1 d0",
                  n_press, n_long, n_rep, n_short, n_dbl);
      end
   endtask

   initial begin
      clear_log();
      test_reset();
      test_short_click();
      test_double_click();
      test_long_repeat();
      test_release_at_expiry();
      test_rise_at_expiry();
      test_reset_mid_gesture();
      test_exclusive();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
